mem_port_arbiter: RTL and testbench

Shares the single SPI external-memory engine (`mem_external`) between the CPU instruction-fetch path and the load/store path. Each requester gets a level-request / single-cycle-acknowledge port. The arbiter picks a winner round-robin, latches its command, and drives the memory engine's start/done handshake. A watchdog aborts transactions the memory never completes. It sits between the CPU core state machine and `mem_external`.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/arb_watchdog.sv | 28 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU-side memory arbitration logic.
package cpu_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_BUSY    = 2'd1;
  localparam logic [1:0] ARB_RELEASE = 2'd2;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  localparam int DEFAULT_ADDR_W = 25;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter that flags a memory transaction that never completes.
module arb_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // TIMEOUT of zero disables expiry entirely; the counter may wrap harmlessly.
  assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the SPI memory engine between fetch and load/store.
//
// state       | meaning
// ARB_IDLE    | waiting for a request; arbitrates and latches the command
// ARB_BUSY    | mem_start high, waiting for mem_done or watchdog expiry
// ARB_RELEASE | mem_start low, waiting for the engine to drop mem_done
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [2:0]        f_num_bytes,
  output logic              f_ack,
  output logic              f_err,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_num_bytes,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_start,
  output logic              mem_is_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_num_bytes,
  output logic [31:0]       mem_wdata,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant
);

  logic [1:0] state;
  logic       last_grant;
  logic       pick_data;
  logic       wd_expired;

  // On a tie the port that did not win last time goes first.
  assign pick_data = d_req && (!f_req || (last_grant == GRANT_FETCH));
  assign busy      = (state != ARB_IDLE);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ARB_BUSY),
    .enable  (state == ARB_BUSY),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      last_grant    <= GRANT_DATA;
      grant         <= GRANT_FETCH;
      mem_start     <= 1'b0;
      mem_is_write  <= 1'b0;
      mem_addr      <= '0;
      mem_num_bytes <= '0;
      mem_wdata     <= '0;
      f_ack         <= 1'b0;
      f_err         <= 1'b0;
      f_rdata       <= '0;
      d_ack         <= 1'b0;
      d_err         <= 1'b0;
      d_rdata       <= '0;
    end else begin
      f_ack <= 1'b0;
      f_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (f_req || d_req) begin
            grant         <= pick_data;
            mem_is_write  <= pick_data & d_we;
            mem_addr      <= pick_data ? d_addr : f_addr;
            mem_num_bytes <= pick_data ? d_num_bytes : f_num_bytes;
            mem_wdata     <= pick_data ? d_wdata : '0;
            mem_start     <= 1'b1;
            state         <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Completion takes priority over a same-edge watchdog expiry.
          if (mem_done) begin
            if (grant == GRANT_DATA) begin
              d_ack   <= 1'b1;
              d_rdata <= mem_rdata;
            end else begin
              f_ack   <= 1'b1;
              f_rdata <= mem_rdata;
            end
            mem_start  <= 1'b0;
            last_grant <= grant;
            state      <= ARB_RELEASE;
          end else if (wd_expired) begin
            if (grant == GRANT_DATA) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              f_ack   <= 1'b1;
              f_err   <= 1'b1;
              f_rdata <= '0;
            end
            mem_start <= 1'b0;
            state     <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          if (!mem_done) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          mem_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a scripted memory responder.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req, d_req, d_we;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic [2:0]        f_num_bytes, d_num_bytes;
  logic [31:0]       d_wdata;
  logic              f_ack, f_err, d_ack, d_err;
  logic [31:0]       f_rdata, d_rdata;
  logic              mem_start, mem_is_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_num_bytes;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              busy, grant;

  int errors = 0;
  int checks = 0;

  int          resp_delay = 0;
  int          resp_hold  = 0;
  logic [31:0] resp_data  = '0;
  int          start_cnt  = 0;
  int          hold_cnt   = 0;
  logic        mon_en     = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .f_req         (f_req),
    .f_addr        (f_addr),
    .f_num_bytes   (f_num_bytes),
    .f_ack         (f_ack),
    .f_err         (f_err),
    .f_rdata       (f_rdata),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_num_bytes   (d_num_bytes),
    .d_wdata       (d_wdata),
    .d_ack         (d_ack),
    .d_err         (d_err),
    .d_rdata       (d_rdata),
    .mem_start     (mem_start),
    .mem_is_write  (mem_is_write),
    .mem_addr      (mem_addr),
    .mem_num_bytes (mem_num_bytes),
    .mem_wdata     (mem_wdata),
    .mem_done      (mem_done),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .grant         (grant)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (mem_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("start_seen", mem_start, 1);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while ((f_ack | d_ack) !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("ack_seen", f_ack | d_ack, 1);
  endtask

  // Engine model: done after resp_delay start cycles (0 = never), held resp_hold extra cycles.
  always @(negedge clk) begin
    if (rst) begin
      mem_done  = 1'b0;
      mem_rdata = '0;
      start_cnt = 0;
      hold_cnt  = 0;
    end else if (mem_start && !mem_done) begin
      start_cnt++;
      if (resp_delay != 0 && start_cnt == resp_delay) begin
        mem_done  = 1'b1;
        mem_rdata = resp_data;
      end
    end else if (mem_done && !mem_start) begin
      if (hold_cnt >= resp_hold) begin
        mem_done  = 1'b0;
        hold_cnt  = 0;
        start_cnt = 0;
      end else begin
        hold_cnt++;
      end
    end else if (!mem_start) begin
      start_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) chk("ack_excl", f_ack & d_ack, 0);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    f_req = 0; d_req = 0; d_we = 0;
    f_addr = '0; d_addr = '0; f_num_bytes = '0; d_num_bytes = '0; d_wdata = '0;
    tick();
    tick();
    chk("rst_start", mem_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_f_ack", f_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Both ports requesting continuously: F, D, F, D with a 2-cycle start gap.
    f_req = 1; f_addr = 25'h0000020; f_num_bytes = 3'd4;
    d_req = 1; d_we = 0; d_addr = 25'h1000004; d_num_bytes = 3'd4;
    resp_delay = 3; resp_hold = 0; resp_data = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      wait_start(n);
      chk("alt_grant", grant, (i % 2 == 1) ? 1 : 0);
      if (i > 0) chk("alt_gap", n, 2);
      wait_ack(n);
      chk("alt_ack_owner", (i % 2 == 1) ? d_ack : f_ack, 1);
      if (i == 3) begin
        chk("alt_d_rdata", d_rdata, 32'h1111_2222);
        f_req = 0;
        d_req = 0;
      end
    end
    tick();
    tick();
    chk("alt_idle", busy, 0);

    // Single fetch.
    f_req = 1; f_addr = 25'h0000010; f_num_bytes = 3'd4;
    resp_delay = 5; resp_data = 32'h0050_0093;
    wait_start(n);
    chk("fetch_start_lat", n, 1);
    chk("fetch_addr", mem_addr, 25'h0000010);
    chk("fetch_nbytes", mem_num_bytes, 4);
    chk("fetch_is_write", mem_is_write, 0);
    chk("fetch_grant", grant, 0);
    wait_ack(n);
    chk("fetch_ack_lat", n, 5);
    chk("fetch_ack", f_ack, 1);
    chk("fetch_rdata", f_rdata, 32'h0050_0093);
    chk("fetch_err", f_err, 0);
    chk("fetch_start_low", mem_start, 0);
    f_req = 0;
    tick();
    chk("fetch_ack_pulse", f_ack, 0);
    tick();
    chk("fetch_idle", busy, 0);

    // Store.
    d_req = 1; d_we = 1; d_addr = 25'h1000100; d_num_bytes = 3'd4; d_wdata = 32'hDEAD_BEEF;
    resp_delay = 4; resp_data = 32'hCAFE_F00D;
    wait_start(n);
    chk("store_grant", grant, 1);
    chk("store_is_write", mem_is_write, 1);
    chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store_addr", mem_addr, 25'h1000100);
    tick();
    chk("store_wdata_busy", mem_wdata, 32'hDEAD_BEEF);
    wait_ack(n);
    chk("store_d_ack", d_ack, 1);
    chk("store_f_ack", f_ack, 0);
    chk("store_err", d_err, 0);
    d_req = 0; d_we = 0;
    tick();
    tick();

    // Watchdog expiry with TIMEOUT = 8.
    d_req = 1; d_addr = 25'h1000200;
    resp_delay = 0;
    wait_start(n);
    wait_ack(n);
    chk("wd_lat", n, 8);
    chk("wd_d_ack", d_ack, 1);
    chk("wd_d_err", d_err, 1);
    chk("wd_rdata", d_rdata, 0);
    chk("wd_f_ack", f_ack, 0);
    chk("wd_start_low", mem_start, 0);
    d_req = 0;
    tick();
    chk("wd_idle", busy, 0);
    tick();

    // Engine holds done for 3 cycles after start drops.
    f_req = 1; f_addr = 25'h0000040;
    resp_delay = 2; resp_hold = 3; resp_data = 32'h0000_0ABC;
    wait_start(n);
    wait_ack(n);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_busy", busy, 1);
      chk("hold_no_start", mem_start, 0);
    end
    resp_hold = 0;
    tick();
    chk("hold_idle", busy, 0);
    chk("hold_idle_start", mem_start, 0);
    tick();
    chk("hold_restart", mem_start, 1);
    wait_ack(n);
    chk("hold_second_ack", f_ack, 1);
    f_req = 0;
    tick();
    tick();

    // Reset mid-BUSY, then a tie must go to fetch.
    d_req = 1; d_addr = 25'h1000300;
    resp_delay = 0;
    wait_start(n);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstb_start", mem_start, 0);
    chk("rstb_busy", busy, 0);
    chk("rstb_d_ack", d_ack, 0);
    resp_delay = 2;
    f_req = 1;
    rst = 1'b0;
    wait_start(n);
    chk("rstb_tie_grant", grant, 0);
    wait_ack(n);
    chk("rstb_f_ack", f_ack, 1);
    f_req = 0;
    d_req = 0;
    tick();
    tick();
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
